// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store.
// One transaction in flight; data side wins ties unless fetch has waited STARVE_MAX grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_if_req,
    input  logic [ADDR_W-1:0] in_if_addr,
    input  logic              in_if_kill,
    output logic              out_if_ack,
    output logic [DATA_W-1:0] out_if_rdata,
    input  logic              in_dm_req,
    input  logic              in_dm_we,
    input  logic [3:0]        in_dm_be,
    input  logic [ADDR_W-1:0] in_dm_addr,
    input  logic [DATA_W-1:0] in_dm_wdata,
    output logic              out_dm_ack,
    output logic [DATA_W-1:0] out_dm_rdata,
    output logic              out_mem_req,
    output logic              out_mem_we,
    output logic [3:0]        out_mem_be,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_mem_wdata,
    input  logic              in_mem_ready,
    input  logic [DATA_W-1:0] in_mem_rdata,
    output logic [1:0]        out_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_BUSY = 2'd1,
        S_DM_BUSY = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              kill_q, kill_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_dm, grant_if;

    // Handshakes: each req is held with its payload until its one-cycle ack; the memory
    // request is held with its fields until in_mem_ready is sampled high.
    assign grant_dm = (state_q == S_IDLE) && in_dm_req && (!in_if_req || starve_q != CNT_MAX);
    assign grant_if = (state_q == S_IDLE) && in_if_req && !grant_dm;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            kill_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            kill_q      <= kill_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_dm)      state_d = S_DM_BUSY;
                else if (grant_if) state_d = S_IF_BUSY;
            end
            S_IF_BUSY, S_DM_BUSY: if (in_mem_ready) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        starve_d    = starve_q;
        kill_d      = kill_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_dm) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = in_dm_we;
                    mem_be_d    = in_dm_we ? in_dm_be : 4'hF;
                    mem_addr_d  = in_dm_addr;
                    mem_wdata_d = in_dm_we ? in_dm_wdata : '0;
                    if (!in_if_req)              starve_d = '0;
                    else if (starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
                end else if (grant_if) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = in_if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            S_IF_BUSY: begin
                if (in_mem_ready) begin
                    mem_req_d = 1'b0;
                    kill_d    = 1'b0;
                    // A kill arriving with ready still discards the fetched word.
                    if (!(kill_q || in_if_kill)) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = in_mem_rdata;
                    end
                end else if (in_if_kill) begin
                    kill_d = 1'b1;
                end
            end
            S_DM_BUSY: begin
                if (in_mem_ready) begin
                    mem_req_d = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!mem_we_q) dm_rdata_d = in_mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign out_if_ack    = if_ack_q;
    assign out_if_rdata  = if_rdata_q;
    assign out_dm_ack    = dm_ack_q;
    assign out_dm_rdata  = dm_rdata_q;
    assign out_mem_req   = mem_req_q;
    assign out_mem_we    = mem_we_q;
    assign out_mem_be    = mem_be_q;
    assign out_mem_addr  = mem_addr_q;
    assign out_mem_wdata = mem_wdata_q;
    assign out_dbg_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_if_req, in_if_kill;
    logic [31:0] in_if_addr;
    logic        out_if_ack;
    logic [31:0] out_if_rdata;
    logic        in_dm_req, in_dm_we;
    logic [3:0]  in_dm_be;
    logic [31:0] in_dm_addr, in_dm_wdata;
    logic        out_dm_ack;
    logic [31:0] out_dm_rdata;
    logic        out_mem_req, out_mem_we;
    logic [3:0]  out_mem_be;
    logic [31:0] out_mem_addr, out_mem_wdata;
    logic        in_mem_ready;
    logic [31:0] in_mem_rdata;
    logic [1:0]  out_dbg_state;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_if_req(in_if_req), .in_if_addr(in_if_addr), .in_if_kill(in_if_kill),
        .out_if_ack(out_if_ack), .out_if_rdata(out_if_rdata),
        .in_dm_req(in_dm_req), .in_dm_we(in_dm_we), .in_dm_be(in_dm_be),
        .in_dm_addr(in_dm_addr), .in_dm_wdata(in_dm_wdata),
        .out_dm_ack(out_dm_ack), .out_dm_rdata(out_dm_rdata),
        .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_be(out_mem_be),
        .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .in_mem_ready(in_mem_ready), .in_mem_rdata(in_mem_rdata),
        .out_dbg_state(out_dbg_state)
    );

    // Clock / reset
    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd);
        chk1({tag, ".mem_req"}, out_mem_req, 1'b1);
        chk32({tag, ".mem_addr"}, out_mem_addr, a);
        chk1({tag, ".mem_we"}, out_mem_we, we);
        chk32({tag, ".mem_be"}, 32'(out_mem_be), 32'(be));
        chk32({tag, ".mem_wdata"}, out_mem_wdata, wd);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, ".if_ack"}, out_if_ack, 1'b0);
        chk32({tag, ".if_rdata"}, out_if_rdata, 32'h0);
        chk1({tag, ".dm_ack"}, out_dm_ack, 1'b0);
        chk32({tag, ".dm_rdata"}, out_dm_rdata, 32'h0);
        chk1({tag, ".mem_req"}, out_mem_req, 1'b0);
        chk1({tag, ".mem_we"}, out_mem_we, 1'b0);
        chk32({tag, ".mem_be"}, 32'(out_mem_be), 32'h0);
        chk32({tag, ".mem_addr"}, out_mem_addr, 32'h0);
        chk32({tag, ".mem_wdata"}, out_mem_wdata, 32'h0);
        chk32({tag, ".state"}, 32'(out_dbg_state), 32'h0);
    endtask

    // Driver tasks
    task automatic new_if();
        in_if_req  = 1'b1;
        in_if_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_dm();
        in_dm_req   = 1'b1;
        in_dm_we    = 1'($urandom_range(0, 1));
        in_dm_be    = 4'($urandom_range(1, 15));
        in_dm_addr  = $urandom & 32'hFFFF_FFFC;
        in_dm_wdata = $urandom;
    endtask

    initial begin
        logic [31:0] m_if_rdata, m_dm_rdata, rd, e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we, win_dm, killed;
        int          m_starve, waits, kill_mode;

        in_rst = 1'b1;
        in_if_req = 1'b0; in_if_addr = '0; in_if_kill = 1'b0;
        in_dm_req = 1'b0; in_dm_we = 1'b0; in_dm_be = '0; in_dm_addr = '0; in_dm_wdata = '0;
        in_mem_ready = 1'b0; in_mem_rdata = '0;
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        in_rst = 1'b0;
        tick();

        // 1. fetch only, ready on the first busy cycle
        in_if_req = 1'b1; in_if_addr = 32'h100;
        tick();
        chk_mem("t1.grant", 32'h100, 1'b0, 4'hF, 32'h0);
        chk1("t1.no_early_ack", out_if_ack, 1'b0);
        in_mem_ready = 1'b1; in_mem_rdata = 32'h0000_0013;
        tick();
        in_mem_ready = 1'b0; in_if_req = 1'b0;
        chk1("t1.if_ack", out_if_ack, 1'b1);
        chk32("t1.if_rdata", out_if_rdata, 32'h13);
        chk1("t1.dm_ack", out_dm_ack, 1'b0);
        chk1("t1.mem_req_drop", out_mem_req, 1'b0);
        tick();
        chk1("t1.ack_one_cycle", out_if_ack, 1'b0);
        chk32("t1.idle", 32'(out_dbg_state), 32'h0);
        m_if_rdata = 32'h13;
        m_dm_rdata = 32'h0;

        // 2. store with three wait cycles
        in_dm_req = 1'b1; in_dm_we = 1'b1; in_dm_be = 4'b0011;
        in_dm_addr = 32'h2000; in_dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk_mem("t2.grant", 32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk_mem("t2.hold", 32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
            chk1("t2.no_ack", out_dm_ack, 1'b0);
        end
        in_mem_ready = 1'b1; in_mem_rdata = 32'h5A5A_5A5A;
        tick();
        in_mem_ready = 1'b0; in_dm_req = 1'b0;
        chk1("t2.dm_ack", out_dm_ack, 1'b1);
        chk1("t2.if_ack", out_if_ack, 1'b0);
        chk32("t2.dm_rdata_kept", out_dm_rdata, m_dm_rdata);
        tick();
        chk1("t2.ack_one_cycle", out_dm_ack, 1'b0);

        // 3. both requesters held: DM x4, then IF, then DM
        in_if_req = 1'b1; in_if_addr = 32'h500;
        in_dm_req = 1'b1; in_dm_we = 1'b0; in_dm_be = 4'h0; in_dm_addr = 32'h600; in_dm_wdata = '0;
        for (int i = 0; i < 6; i++) begin
            win_dm = (i != 4);
            tick();
            chk32("t3.grant_addr", out_mem_addr, win_dm ? 32'h600 : 32'h500);
            in_mem_ready = 1'b1; in_mem_rdata = 32'h1000 + 32'(i);
            tick();
            in_mem_ready = 1'b0;
            chk1("t3.dm_ack", out_dm_ack, win_dm);
            chk1("t3.if_ack", out_if_ack, !win_dm);
            if (win_dm) m_dm_rdata = 32'h1000 + 32'(i);
            else        m_if_rdata = 32'h1000 + 32'(i);
            if (i == 5) begin
                in_if_req = 1'b0; in_dm_req = 1'b0;
            end
            tick();
        end
        chk32("t3.if_rdata", out_if_rdata, m_if_rdata);
        chk32("t3.dm_rdata", out_dm_rdata, m_dm_rdata);

        // 4a. kill during a wait cycle of a fetch
        in_if_req = 1'b1; in_if_addr = 32'h300;
        tick();
        in_if_kill = 1'b1;
        tick();
        in_if_kill = 1'b0;
        in_mem_ready = 1'b1; in_mem_rdata = 32'h0BAD_0BAD;
        tick();
        in_mem_ready = 1'b0; in_if_req = 1'b0;
        chk1("t4a.no_if_ack", out_if_ack, 1'b0);
        chk1("t4a.no_dm_ack", out_dm_ack, 1'b0);
        chk32("t4a.if_rdata", out_if_rdata, m_if_rdata);
        tick();
        chk32("t4a.idle", 32'(out_dbg_state), 32'h0);
        // 4b. kill coincident with ready
        in_if_req = 1'b1; in_if_addr = 32'h304;
        tick();
        in_mem_ready = 1'b1; in_if_kill = 1'b1; in_mem_rdata = 32'h0BAD_1111;
        tick();
        in_mem_ready = 1'b0; in_if_kill = 1'b0; in_if_req = 1'b0;
        chk1("t4b.no_if_ack", out_if_ack, 1'b0);
        chk32("t4b.if_rdata", out_if_rdata, m_if_rdata);
        tick();
        chk32("t4b.idle", 32'(out_dbg_state), 32'h0);

        // 5. asynchronous reset in the middle of a load
        in_dm_req = 1'b1; in_dm_we = 1'b0; in_dm_addr = 32'h700;
        tick();
        chk1("t5.mem_req", out_mem_req, 1'b1);
        tick();
        #2 in_rst = 1'b1;
        #1;
        chk_all_zero("t5.async_reset");
        #2 in_rst = 1'b0;
        in_dm_req = 1'b0;
        tick();
        chk_all_zero("t5.after_reset");
        in_if_req = 1'b1; in_if_addr = 32'h400;
        tick();
        chk_mem("t5.fresh_grant", 32'h400, 1'b0, 4'hF, 32'h0);
        in_mem_ready = 1'b1; in_mem_rdata = 32'h55;
        tick();
        in_mem_ready = 1'b0; in_if_req = 1'b0;
        chk1("t5.if_ack", out_if_ack, 1'b1);
        chk32("t5.if_rdata", out_if_rdata, 32'h55);
        tick();
        m_if_rdata = 32'h55;
        m_dm_rdata = 32'h0;
        m_starve = 0;

        // Randomized traffic against the transaction-level model
        for (int r = 0; r < 120; r++) begin
            if (!in_if_req && $urandom_range(0, 3) != 0) new_if();
            if (!in_dm_req && $urandom_range(0, 3) != 0) new_dm();
            if (!in_if_req && !in_dm_req) begin
                in_if_kill = 1'($urandom_range(0, 1));
                tick();
                in_if_kill = 1'b0;
                chk1("rnd.idle_mem_req", out_mem_req, 1'b0);
                chk32("rnd.idle_state", 32'(out_dbg_state), 32'h0);
                continue;
            end
            win_dm = in_dm_req && (!in_if_req || m_starve < STARVE_MAX);
            if (win_dm) m_starve = in_if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
            else        m_starve = 0;
            e_addr  = win_dm ? in_dm_addr : in_if_addr;
            e_we    = win_dm ? in_dm_we : 1'b0;
            e_be    = (win_dm && in_dm_we) ? in_dm_be : 4'hF;
            e_wdata = (win_dm && in_dm_we) ? in_dm_wdata : 32'h0;
            tick();
            chk_mem("rnd.grant", e_addr, e_we, e_be, e_wdata);
            waits = $urandom_range(0, 3);
            kill_mode = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                in_if_kill = (kill_mode == 1 && w == 0);
                tick();
                in_if_kill = 1'b0;
                chk_mem("rnd.hold", e_addr, e_we, e_be, e_wdata);
                chk1("rnd.no_ack", out_if_ack | out_dm_ack, 1'b0);
            end
            killed = !win_dm && ((kill_mode == 1 && waits > 0) || kill_mode == 2);
            rd = $urandom;
            in_mem_rdata = rd; in_mem_ready = 1'b1; in_if_kill = (kill_mode == 2);
            if (win_dm) begin
                if (!in_dm_we) m_dm_rdata = rd;
            end else if (!killed) begin
                m_if_rdata = rd;
            end
            exp_q.push_back(m_if_rdata);
            exp_q.push_back(m_dm_rdata);
            tick();
            in_mem_ready = 1'b0; in_if_kill = 1'b0;
            chk1("rnd.dm_ack", out_dm_ack, win_dm);
            chk1("rnd.if_ack", out_if_ack, !win_dm && !killed);
            chk1("rnd.mem_req_drop", out_mem_req, 1'b0);
            chk32("rnd.if_rdata", out_if_rdata, exp_q.pop_front());
            chk32("rnd.dm_rdata", out_dm_rdata, exp_q.pop_front());
            if (win_dm) in_dm_req = 1'b0;
            else        in_if_req = 1'b0;
            tick();
            chk1("rnd.ack_one_cycle", out_if_ack | out_dm_ack, 1'b0);
            chk32("rnd.back_idle", 32'(out_dbg_state), 32'h0);
        end
        chk32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
